// File: rtl/norm_shift.sv
// Iterative normalizer: finds the left shift that normalizes a word (leading zeros or
// redundant sign bits) by trying shifts of 16, 8, 4, 2 and 1, one per clock.
module norm_shift #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [SHW-1:0]   shift,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is 1 only in IDLE; out_valid is 1 only in DONE, and the outputs are held
  // until out_ready is seen. Neither valid depends combinationally on the other side's ready.

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] work, work_nx;
  logic [SHW-1:0]   acc, acc_nx;
  logic [SHW-1:0]   step, step_nx;
  logic             arith_q, arith_nx;
  logic             zero_q, zero_nx;

  logic [SHW-1:0]   shamt;
  logic [SHW:0]     n;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] probe;
  logic             hit;

  // Stage k tries n = 2**(SHW-1-k). In arith mode, the top n bits of work^(work<<1)
  // are zero exactly when the top n+1 bits of work are all equal.
  always_comb begin
    shamt = SHW'(SHW - 1) - step;
    n     = {{SHW{1'b0}}, 1'b1} << shamt;
    mask  = ~({WIDTH{1'b1}} >> n);
    probe = arith_q ? (work ^ (work << 1)) : work;
    hit   = ((probe & mask) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      work    <= '0;
      acc     <= '0;
      step    <= '0;
      arith_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      work    <= work_nx;
      acc     <= acc_nx;
      step    <= step_nx;
      arith_q <= arith_nx;
      zero_q  <= zero_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    work_nx   = work;
    acc_nx    = acc;
    step_nx   = step;
    arith_nx  = arith_q;
    zero_nx   = zero_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_nx  = data;
          arith_nx = arith;
          zero_nx  = (data == '0);
          acc_nx   = '0;
          step_nx  = '0;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (hit) begin
          work_nx = work << n;
          acc_nx  = acc + n[SHW-1:0];
        end
        step_nx = step + 1'b1;
        if (step == SHW'(SHW - 1)) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign result    = work;
  assign shift     = acc;
  assign zero      = zero_q;
  assign dbg_state = state;

endmodule
